// File: rtl/wb_initiator_pkg.sv
// Shared types and default widths for the Wishbone B4 classic initiator BFM.
package wb_initiator_pkg;

  localparam int WB_ADDR_WIDTH     = 32;
  localparam int WB_DATA_WIDTH     = 32;
  localparam int WB_SEL_WIDTH      = WB_DATA_WIDTH / 8;
  localparam int WB_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    GAP  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                     we;
    logic [WB_ADDR_WIDTH-1:0] adr;
    logic [WB_DATA_WIDTH-1:0] dat;
    logic [WB_SEL_WIDTH-1:0]  sel;
  } wb_req_t;

  typedef struct packed {
    logic [WB_DATA_WIDTH-1:0] dat;
    logic                     err;
  } wb_rsp_t;

endpackage

// File: rtl/wb_initiator_bfm.sv
// Single-outstanding Wishbone B4 classic initiator: one bus cycle per request.
// Optional bus watchdog enabled by defining WB_INITIATOR_TIMEOUT_EN.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request handshake
// BUS   | cyc/stb asserted, waiting for ack/err (or watchdog expiry)
// GAP   | one dead cycle so a registered target's stale ack is ignored
module wb_initiator_bfm
  import wb_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_adr,
  input  logic [DATA_WIDTH-1:0]   req_dat,
  input  logic [DATA_WIDTH/8-1:0] req_sel,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_dat,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   adr,
  output logic [DATA_WIDTH-1:0]   dat_w,
  input  logic [DATA_WIDTH-1:0]   dat_r,
  output logic                    cyc,
  output logic                    stb,
  output logic                    we,
  output logic [DATA_WIDTH/8-1:0] sel,
  input  logic                    ack,
  input  logic                    err
);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  wb_state_e               r_state;
  logic                    r_req_ready;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_dat;
  logic                    r_rsp_err;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]   r_dat_w;
  logic                    r_cyc;
  logic                    r_stb;
  logic                    r_we;
  logic [DATA_WIDTH/8-1:0] r_sel;

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_adr       <= '0;
      r_dat_w     <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
      r_tmo_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 1'b0;
          if (req_valid && r_req_ready) begin
            r_adr       <= req_adr;
            r_dat_w     <= req_dat;
            r_sel       <= req_sel;
            r_we        <= req_we;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_req_ready <= 1'b0;
            r_state     <= BUS;
`ifdef WB_INITIATOR_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        BUS: begin
          // err wins over a simultaneous ack; read data is captured either way
          if (ack || err) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= dat_r;
            r_rsp_err   <= err;
            r_state     <= GAP;
          end
`ifdef WB_INITIATOR_TIMEOUT_EN
          else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= GAP;
          end
          r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
`endif
        end
        GAP: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign adr       = r_adr;
  assign dat_w     = r_dat_w;
  assign cyc       = r_cyc;
  assign stb       = r_stb;
  assign we        = r_we;
  assign sel       = r_sel;

endmodule

// File: tb/tb_wb_initiator_bfm.sv
// Directed scoreboard bench for wb_initiator_bfm against a registered-ack target.
module tb_wb_initiator_bfm;
  import wb_initiator_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_adr = '0;
  logic [DW-1:0] req_dat = '0;
  logic [SW-1:0] req_sel = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          cyc;
  logic          stb;
  logic          we;
  logic [SW-1:0] sel;
  logic          ack = 1'b0;
  logic          err = 1'b0;

  logic [DW-1:0] tgt_mem = '0;
  logic          tgt_silent = 1'b0;
  logic          tgt_err_mode = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  wb_rsp_t sb_q[$];

  wb_initiator_bfm #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .adr(adr), .dat_w(dat_w), .dat_r(dat_r),
    .cyc(cyc), .stb(stb), .we(we), .sel(sel),
    .ack(ack), .err(err)
  );

  always #5 clock = ~clock;

  // registered-ack target with a single data register
  always @(posedge clock) begin
    if (reset) begin
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      ack <= cyc && stb && !tgt_silent;
      err <= cyc && stb && !tgt_silent && tgt_err_mode;
      if (cyc && stb && we && !tgt_silent) tgt_mem <= dat_w;
    end
  end
  assign dat_r = tgt_mem;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic [DW-1:0] exp_dat, input logic exp_err);
    int n;
    wb_rsp_t r;
    req_we = w; req_adr = a; req_dat = d; req_sel = s; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'(1));
    r.dat = exp_dat;
    r.err = exp_err;
    sb_q.push_back(r);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc_hi, output logic we_obs, output logic [AW-1:0] adr_obs);
    logic    got;
    wb_rsp_t r;
    got = 1'b0; cyc_hi = 0; we_obs = 1'bx; adr_obs = 'x;
    for (int i = 0; i < 50 && !got; i++) begin
      if (rsp_valid) got = 1'b1;
      else begin
        if (cyc) begin
          cyc_hi++;
          we_obs = we;
          adr_obs = adr;
        end
        @(negedge clock);
      end
    end
    chk("rsp_seen", 64'(got), 64'(1));
    if (got) begin
      chk("sb_nonempty", 64'(sb_q.size() > 0), 64'(1));
      if (sb_q.size() > 0) begin
        r = sb_q.pop_front();
        chk("rsp_dat", 64'(rsp_dat), 64'(r.dat));
        chk("rsp_err", 64'(rsp_err), 64'(r.err));
        chk("cyc_drop", 64'(cyc), 64'(0));
        @(negedge clock);
        chk("rsp_pulse", 64'(rsp_valid), 64'(0));
        chk("rsp_hold", 64'(rsp_dat), 64'(r.dat));
      end
    end
  endtask

  initial begin
    int            cyc_hi;
    logic          we_obs;
    logic [AW-1:0] adr_obs;
    wb_req_t       b2b[4];
    logic [DW-1:0] b2b_exp[4];
    int            idx, done_rsp, low_cnt;
    logic          prev_cyc, seen_bus, hs;
    wb_rsp_t       r;

    // reset held with a pending request
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h55; req_dat = 32'h77; req_sel = 4'hF;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk("rst_cyc", 64'(cyc), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
    end
    chk("rst_outs", 64'({stb, we, rsp_valid, rsp_err, sel}), 64'(0));
    chk("rst_buses", 64'({adr, dat_w}), 64'(0));
    chk("rst_rsp_dat", 64'(rsp_dat), 64'(0));
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", 64'(req_ready), 64'(1));

    // write then read back
    send(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0);
    wait_rsp(cyc_hi, we_obs, adr_obs);
    chk("wr_cyc_len", 64'(cyc_hi), 64'(2));
    chk("wr_we", 64'(we_obs), 64'(1));
    chk("wr_adr", 64'(adr_obs), 64'(32'h100));
    chk("wr_mem", 64'(tgt_mem), 64'(32'hDEADBEEF));

    send(1'b0, 32'h200, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    wait_rsp(cyc_hi, we_obs, adr_obs);
    chk("rd_we", 64'(we_obs), 64'(0));
    chk("rd_adr", 64'(adr_obs), 64'(32'h200));

    // back-to-back with req_valid held high
    b2b[0] = '{we: 1'b1, adr: 32'h300, dat: 32'hA5A50001, sel: 4'hF};
    b2b[1] = '{we: 1'b0, adr: 32'h304, dat: 32'h0,        sel: 4'hF};
    b2b[2] = '{we: 1'b1, adr: 32'h308, dat: 32'h12345678, sel: 4'h3};
    b2b[3] = '{we: 1'b0, adr: 32'h30C, dat: 32'h0,        sel: 4'hF};
    b2b_exp[0] = 32'hA5A50001; b2b_exp[1] = 32'hA5A50001;
    b2b_exp[2] = 32'h12345678; b2b_exp[3] = 32'h12345678;
    idx = 0; done_rsp = 0; low_cnt = 0; prev_cyc = 1'b0; seen_bus = 1'b0;
    {req_we, req_adr, req_dat, req_sel} = b2b[0];
    req_valid = 1'b1;
    for (int c = 0; c < 80 && done_rsp < 4; c++) begin
      if (rsp_valid) begin
        if (sb_q.size() > 0) begin
          r = sb_q.pop_front();
          chk("b2b_dat", 64'(rsp_dat), 64'(r.dat));
          chk("b2b_err", 64'(rsp_err), 64'(r.err));
        end else chk("b2b_extra_rsp", 64'(0), 64'(1));
        done_rsp++;
      end
      if (cyc && !prev_cyc) begin
        if (seen_bus) chk("b2b_cyc_gap", 64'(low_cnt >= 1), 64'(1));
        seen_bus = 1'b1;
      end
      low_cnt = cyc ? 0 : low_cnt + 1;
      prev_cyc = cyc;
      hs = req_valid && req_ready;
      if (hs) begin
        r.dat = b2b_exp[idx];
        r.err = 1'b0;
        sb_q.push_back(r);
      end
      @(negedge clock);
      if (hs) begin
        idx++;
        if (idx < 4) {req_we, req_adr, req_dat, req_sel} = b2b[idx];
        else req_valid = 1'b0;
      end
    end
    chk("b2b_rsp_count", 64'(done_rsp), 64'(4));
    repeat (3) @(negedge clock);
    chk("b2b_no_stray", 64'(rsp_valid), 64'(0));
    chk("b2b_sb_empty", 64'(sb_q.size()), 64'(0));

    // err together with ack
    tgt_err_mode = 1'b1;
    send(1'b0, 32'h400, 32'h0, 4'hF, 32'h12345678, 1'b1);
    wait_rsp(cyc_hi, we_obs, adr_obs);
    tgt_err_mode = 1'b0;

    // silent target
    tgt_silent = 1'b1;
`ifdef WB_INITIATOR_TIMEOUT_EN
    send(1'b0, 32'h500, 32'h0, 4'hF, 32'h0, 1'b1);
    wait_rsp(cyc_hi, we_obs, adr_obs);
    chk("tmo_cyc_len", 64'(cyc_hi), 64'(TO));
`else
    req_we = 1'b0; req_adr = 32'h500; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    cyc_hi = 0; hs = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (cyc) cyc_hi++;
      if (rsp_valid) hs = 1'b1;
      @(negedge clock);
    end
    chk("hang_cyc_len", 64'(cyc_hi), 64'(30));
    chk("hang_no_rsp", 64'(hs), 64'(0));
    reset = 1'b1;
    @(negedge clock);
    chk("abort_cyc", 64'({cyc, stb}), 64'(0));
    chk("abort_rsp", 64'(rsp_valid), 64'(0));
    reset = 1'b0;
    hs = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (rsp_valid) hs = 1'b1;
    end
    chk("abort_no_rsp", 64'(hs), 64'(0));
    chk("abort_ready", 64'(req_ready), 64'(1));
`endif
    tgt_silent = 1'b0;
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
